// File: rtl/vi_supervisor_mc_if.sv
// Sample stream and threshold bundle feeding the V-I supervisor.
// The ADC side drives (master); the supervisor observes (slave).
interface vi_supervisor_mc_if #(
   parameter int W   = 16,
   parameter int NCH = 2
);
   logic                    sample_valid;
   logic [NCH*W-1:0]        v_in;
   logic [NCH*W-1:0]        i_in;
   logic signed [W-1:0]     v_max;
   logic signed [W-1:0]     v_min;
   logic signed [W-1:0]     i_max;

   modport master (output sample_valid, v_in, i_in, v_max, v_min, i_max);
   modport slave  (input  sample_valid, v_in, i_in, v_max, v_min, i_max);
endinterface

// File: rtl/vi_supervisor_mc.sv
// Multi-channel V-I supervisor: debounced ov/uv/oc trips gate the PID enables,
// with soft-start, bounded retry with back-off, and a hard lockout.
module vi_supervisor_mc #(
   parameter int W             = 16,
   parameter int NCH           = 2,
   parameter int DEBOUNCE      = 4,
   parameter int SOFTSTART_CYC = 256,
   parameter int RETRY_MAX     = 3,
   parameter int RETRY_WAIT    = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   clear_fault,
   vi_supervisor_mc_if.slave      bus,
   output logic                   pid_en,
   output logic                   soft_start,
   output logic                   fault,
   output logic [2:0]             state,
   output logic [NCH-1:0]         fault_ch,
   output logic [2:0]             fault_cause,
   output logic [((RETRY_MAX > 0) ? $clog2(RETRY_MAX+1) : 1)-1:0] retry_cnt
);
   localparam int CW   = $clog2(DEBOUNCE + 1);
   localparam int RW   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam int TMAX = (SOFTSTART_CYC > RETRY_WAIT) ? SOFTSTART_CYC : RETRY_WAIT;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [CW-1:0] DMAX      = CW'(DEBOUNCE);
   localparam logic [RW-1:0] RMAX      = RW'(RETRY_MAX);
   localparam logic [TW-1:0] SOFT_LOAD = TW'(SOFTSTART_CYC - 1);
   localparam logic [TW-1:0] WAIT_LOAD = TW'(RETRY_WAIT - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0, SOFT = 3'd1, RUN = 3'd2, FAULT = 3'd3, WAIT = 3'd4, LOCKOUT = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [RW-1:0]   retry_d;
   logic            clr_cnt, clr_sticky, enter_fault;
   logic [NCH-1:0]  ov_raw, uv_raw, oc_raw, ov_trip, uv_trip, oc_trip, trip_ch;
   logic            trip_any, raw_ovoc, ovoc_act, uv_act, hold_all, hold_uv;

   // Counter value after this cycle's sample; trips are judged on it so the
   // tripping sample itself takes effect on the same edge.
   function automatic logic [CW-1:0] deb_next(input logic hold, input logic valid,
                                              input logic cond, input logic [CW-1:0] cur);
      if (hold)   return '0;
      if (!valid) return cur;
      if (!cond)  return '0;
      return (cur == DMAX) ? cur : cur + 1'b1;
   endfunction

   assign ovoc_act = (state_q == SOFT) || (state_q == RUN);
   assign uv_act   = (state_q == RUN);
   assign hold_all = !(state_q inside {SOFT, RUN, FAULT, WAIT});
   assign hold_uv  = hold_all || (state_q == SOFT);

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic signed [W-1:0] v_k, i_k;
      logic [CW-1:0]       ov_q, uv_q, oc_q, ov_n, uv_n, oc_n;

      assign v_k       = bus.v_in[k*W +: W];
      assign i_k       = bus.i_in[k*W +: W];
      assign ov_raw[k] = v_k > $signed(bus.v_max);
      assign uv_raw[k] = v_k < $signed(bus.v_min);
      assign oc_raw[k] = i_k > $signed(bus.i_max);
      assign ov_n      = deb_next(hold_all, bus.sample_valid, ov_raw[k], ov_q);
      assign uv_n      = deb_next(hold_uv,  bus.sample_valid, uv_raw[k], uv_q);
      assign oc_n      = deb_next(hold_all, bus.sample_valid, oc_raw[k], oc_q);
      assign ov_trip[k] = ovoc_act && (ov_n == DMAX);
      assign uv_trip[k] = uv_act   && (uv_n == DMAX);
      assign oc_trip[k] = ovoc_act && (oc_n == DMAX);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ov_q <= '0;
            uv_q <= '0;
            oc_q <= '0;
         end else if (clr_cnt) begin
            ov_q <= '0;
            uv_q <= '0;
            oc_q <= '0;
         end else begin
            ov_q <= ov_n;
            uv_q <= uv_n;
            oc_q <= oc_n;
         end
      end
   end

   assign trip_ch  = ov_trip | uv_trip | oc_trip;
   assign trip_any = |trip_ch;
   assign raw_ovoc = |(ov_raw | oc_raw);

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      retry_d    = retry_cnt;
      clr_cnt    = 1'b0;
      clr_sticky = 1'b0;
      case (state_q)
         IDLE: if (start && !stop) begin
            state_d = SOFT;
            timer_d = SOFT_LOAD;
            retry_d = '0;
         end
         SOFT: begin
            if (trip_any)             state_d = FAULT;
            else if (stop)            state_d = IDLE;
            else if (timer_q == '0)   state_d = RUN;
            else                      timer_d = timer_q - 1'b1;
         end
         RUN: begin
            if (trip_any)    state_d = FAULT;
            else if (stop)   state_d = IDLE;
         end
         FAULT: begin
            if (retry_cnt < RMAX) begin
               state_d = WAIT;
               timer_d = WAIT_LOAD;
            end else begin
               state_d = LOCKOUT;
            end
         end
         WAIT: begin
            if (stop) begin
               state_d = IDLE;
            end else if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else if (!raw_ovoc) begin
               state_d = SOFT;
               timer_d = SOFT_LOAD;
               retry_d = retry_cnt + 1'b1;
               clr_cnt = 1'b1;
            end else begin
               timer_d = WAIT_LOAD;
            end
         end
         LOCKOUT: if (clear_fault && !raw_ovoc) begin
            state_d    = IDLE;
            retry_d    = '0;
            clr_sticky = 1'b1;
         end
         default: begin
            state_d    = IDLE;
            timer_d    = '0;
            retry_d    = '0;
            clr_sticky = 1'b1;
         end
      endcase
   end

   assign enter_fault = (state_d == FAULT) && (state_q != FAULT);
   assign state       = state_q;

   // Outputs are registered from state_d so they line up with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         retry_cnt   <= '0;
         pid_en      <= 1'b0;
         soft_start  <= 1'b0;
         fault       <= 1'b0;
         fault_ch    <= '0;
         fault_cause <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         retry_cnt  <= retry_d;
         pid_en     <= (state_d == SOFT) || (state_d == RUN);
         soft_start <= (state_d == SOFT);
         fault      <= state_d inside {FAULT, WAIT, LOCKOUT};
         if (clr_sticky) begin
            fault_ch    <= '0;
            fault_cause <= '0;
         end else if (enter_fault) begin
            fault_ch    <= fault_ch | trip_ch;
            fault_cause <= fault_cause | {(|oc_trip), (|uv_trip), (|ov_trip)};
         end
      end
   end
endmodule

// File: tb/tb_vi_supervisor_mc.sv
// Directed test-plan scenarios plus a randomized run, each cycle checked
// against a behavioural model of the supervisor rules.
module tb_vi_supervisor_mc;
   localparam int W = 16, NCH = 2, DEB = 4, SOFTC = 8, RMAX = 2, RWAIT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, clear_fault = 1'b0;
   logic       pid_en, soft_start, fault;
   logic [2:0] state;
   logic [1:0] fault_ch;
   logic [2:0] fault_cause;
   logic [1:0] retry_cnt;

   int n_total = 0, n_pass = 0, n_fail = 0;

   vi_supervisor_mc_if #(.W(W), .NCH(NCH)) bus ();

   vi_supervisor_mc #(
      .W(W), .NCH(NCH), .DEBOUNCE(DEB), .SOFTSTART_CYC(SOFTC),
      .RETRY_MAX(RMAX), .RETRY_WAIT(RWAIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear_fault(clear_fault),
      .bus(bus), .pid_en(pid_en), .soft_start(soft_start), .fault(fault), .state(state),
      .fault_ch(fault_ch), .fault_cause(fault_cause), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   // Model: mode 0..5 = idle/soft/run/fault/wait/lockout, elapsed-cycle count
   // in the timed phases, consecutive out-of-range sample run lengths.
   int         m_mode, m_elapsed, m_retries;
   int         m_run[3][NCH];   // [0]=ov, [1]=uv, [2]=oc
   logic [1:0] m_fch;
   logic [2:0] m_fcause;

   task automatic model_reset();
      m_mode = 0; m_elapsed = 0; m_retries = 0; m_fch = '0; m_fcause = '0;
      for (int c = 0; c < 3; c++) for (int k = 0; k < NCH; k++) m_run[c][k] = 0;
   endtask

   task automatic model_step();
      bit out_of_range[3][NCH];
      bit tripped[3][NCH];
      bit any_trip = 0, any_ovoc = 0;
      logic [1:0] tch = '0;
      logic [2:0] tc = '0;
      int v, i;
      for (int k = 0; k < NCH; k++) begin
         v = int'($signed(bus.v_in[k*W +: W]));
         i = int'($signed(bus.i_in[k*W +: W]));
         out_of_range[0][k] = v > int'(bus.v_max);
         out_of_range[1][k] = v < int'(bus.v_min);
         out_of_range[2][k] = i > int'(bus.i_max);
         any_ovoc |= out_of_range[0][k] | out_of_range[2][k];
      end
      for (int c = 0; c < 3; c++) begin
         for (int k = 0; k < NCH; k++) begin
            if (m_mode == 0 || m_mode == 5 || (c == 1 && m_mode == 1)) m_run[c][k] = 0;
            else if (bus.sample_valid)
               m_run[c][k] = out_of_range[c][k] ? ((m_run[c][k] + 1 > DEB) ? DEB : m_run[c][k] + 1) : 0;
            tripped[c][k] = (m_run[c][k] == DEB) &&
                            ((c == 1) ? (m_mode == 2) : (m_mode == 1 || m_mode == 2));
            if (tripped[c][k]) begin
               tch[k] = 1'b1; tc[c] = 1'b1; any_trip = 1;
            end
         end
      end
      case (m_mode)
         0: if (start && !stop) begin m_mode = 1; m_elapsed = 0; m_retries = 0; end
         1, 2: begin
            if (any_trip) begin
               m_mode = 3; m_fch |= tch; m_fcause |= tc;
            end else if (stop) m_mode = 0;
            else if (m_mode == 1) begin
               m_elapsed++;
               if (m_elapsed == SOFTC) m_mode = 2;
            end
         end
         3: begin
            m_elapsed = 0;
            m_mode = (m_retries < RMAX) ? 4 : 5;
         end
         4: begin
            if (stop) m_mode = 0;
            else begin
               m_elapsed++;
               if (m_elapsed == RWAIT) begin
                  m_elapsed = 0;
                  if (!any_ovoc) begin
                     m_mode = 1; m_retries++;
                     for (int c = 0; c < 3; c++) for (int k = 0; k < NCH; k++) m_run[c][k] = 0;
                  end
               end
            end
         end
         5: if (clear_fault && !any_ovoc) begin
            m_mode = 0; m_retries = 0; m_fch = '0; m_fcause = '0;
         end
         default: m_mode = 0;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".state"}, 32'(state), 32'(m_mode));
      chk({tag, ".pid_en"}, 32'(pid_en), 32'(m_mode == 1 || m_mode == 2));
      chk({tag, ".soft_start"}, 32'(soft_start), 32'(m_mode == 1));
      chk({tag, ".fault"}, 32'(fault), 32'(m_mode >= 3 && m_mode <= 5));
      chk({tag, ".fault_ch"}, 32'(fault_ch), 32'(m_fch));
      chk({tag, ".fault_cause"}, 32'(fault_cause), 32'(m_fcause));
      chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(m_retries));
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic step_n(input int n, input string tag);
      for (int j = 0; j < n; j++) step(tag);
   endtask

   task automatic step_until(input int target, input int budget, input string tag);
      for (int j = 0; j < budget; j++) begin
         step(tag);
         if (state === 3'(target)) break;
      end
      chk({tag, ".reached"}, 32'(state), 32'(target));
   endtask

   task automatic set_ch(input int k, input logic [15:0] v, input logic [15:0] i);
      bus.v_in[k*W +: W] = v;
      bus.i_in[k*W +: W] = i;
   endtask

   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      start = 1'b0; stop = 1'b0; clear_fault = 1'b0;
      set_ch(0, 16'h3000, 16'h2000);
      set_ch(1, 16'h3000, 16'h2000);
      #2;
      model_reset();
      chk({tag, ".rst_state"}, 32'(state), 32'd0);
      chk({tag, ".rst_outs"}, {26'd0, pid_en, soft_start, fault, fault_ch, fault_cause[0]}, 32'd0);
      check_model(tag);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic power_up(input string tag);
      start = 1'b1;
      step(tag);
      start = 1'b0;
      step_n(SOFTC, tag);
   endtask

   function automatic logic [15:0] pick_v();
      case ($urandom_range(0, 5))
         0: return 16'h0800;
         1: return 16'h1000;
         2: return 16'h6000;
         3: return 16'h6001;
         4: return 16'h7000;
         default: return 16'h3000;
      endcase
   endfunction

   function automatic logic [15:0] pick_i();
      case ($urandom_range(0, 3))
         0: return 16'h5000;
         1: return 16'h5001;
         default: return 16'h2000;
      endcase
   endfunction

   initial begin
      bus.sample_valid = 1'b1;
      bus.v_max = 16'sh6000;
      bus.v_min = 16'sh1000;
      bus.i_max = 16'sh5000;
      bus.v_in = '0;
      bus.i_in = '0;

      // Nominal power-up and stop
      apply_reset("t1");
      start = 1'b1;
      step("t1.start");
      start = 1'b0;
      chk("t1.soft", 32'(state), 32'd1);
      chk("t1.soft_start", 32'(soft_start), 32'd1);
      step_n(SOFTC - 1, "t1.soft");
      chk("t1.still_soft", 32'(state), 32'd1);
      step("t1.run");
      chk("t1.run", 32'(state), 32'd2);
      chk("t1.run_pid", 32'(pid_en), 32'd1);
      stop = 1'b1;
      step("t1.stop");
      stop = 1'b0;
      chk("t1.idle", 32'(state), 32'd0);
      chk("t1.idle_pid", 32'(pid_en), 32'd0);

      // Debounce on ch1 overcurrent
      apply_reset("t2");
      power_up("t2.up");
      set_ch(1, 16'h3000, 16'h5001);
      step_n(3, "t2.oc3");
      chk("t2.no_trip", 32'(state), 32'd2);
      set_ch(1, 16'h3000, 16'h4000);
      step("t2.gap");
      set_ch(1, 16'h3000, 16'h5001);
      step_n(3, "t2.oc3b");
      chk("t2.no_trip_b", 32'(state), 32'd2);
      step("t2.oc4");
      chk("t2.fault", 32'(state), 32'd3);
      chk("t2.fault_ch", 32'(fault_ch), 32'h2);
      chk("t2.cause", 32'(fault_cause), 32'h4);

      // Undervoltage masked in SOFT
      apply_reset("t3");
      set_ch(0, 16'h0800, 16'h2000);
      power_up("t3.up");
      chk("t3.run", 32'(state), 32'd2);
      step_n(3, "t3.uv");
      chk("t3.no_trip", 32'(state), 32'd2);
      step("t3.uv4");
      chk("t3.fault", 32'(state), 32'd3);
      chk("t3.cause", 32'(fault_cause), 32'h2);

      // Retry, back-off reload and lockout
      apply_reset("t4");
      power_up("t4.up");
      set_ch(0, 16'h7000, 16'h2000);
      step_until(3, 10, "t4.f1");
      chk("t4.cause", 32'(fault_cause), 32'h1);
      step_until(4, 3, "t4.w1");
      step_n(40, "t4.reload");
      chk("t4.still_wait", 32'(state), 32'd4);
      set_ch(0, 16'h3000, 16'h2000);
      step_until(1, 40, "t4.retry1");
      chk("t4.retry1_cnt", 32'(retry_cnt), 32'd1);
      set_ch(0, 16'h7000, 16'h2000);
      step_until(3, 10, "t4.f2");
      step_until(4, 3, "t4.w2");
      set_ch(0, 16'h3000, 16'h2000);
      step_until(1, 40, "t4.retry2");
      chk("t4.retry2_cnt", 32'(retry_cnt), 32'd2);
      set_ch(0, 16'h7000, 16'h2000);
      step_until(3, 10, "t4.f3");
      step_until(5, 3, "t4.lock");
      chk("t4.lock_fault", 32'(fault), 32'd1);
      clear_fault = 1'b1;
      stop = 1'b1;
      step("t4.clr_blocked");
      stop = 1'b0;
      chk("t4.stay_lock", 32'(state), 32'd5);
      set_ch(0, 16'h3000, 16'h2000);
      step("t4.clr");
      clear_fault = 1'b0;
      chk("t4.idle", 32'(state), 32'd0);
      chk("t4.sticky", {27'd0, fault_ch, fault_cause}, 32'd0);
      chk("t4.retry_clr", 32'(retry_cnt), 32'd0);

      // Trip beats stop
      apply_reset("t5");
      power_up("t5.up");
      set_ch(0, 16'h3000, 16'h5001);
      step_n(3, "t5.oc3");
      stop = 1'b1;
      step("t5.both");
      stop = 1'b0;
      chk("t5.fault", 32'(state), 32'd3);

      // Asynchronous reset mid-WAIT
      apply_reset("t6");
      power_up("t6.up");
      set_ch(0, 16'h7000, 16'h2000);
      step_until(4, 10, "t6.wait");
      step_n(3, "t6.inwait");
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6.async_state", 32'(state), 32'd0);
      chk("t6.async_fault", 32'(fault), 32'd0);
      check_model("t6.async");
      #2;
      rst_n = 1'b1;
      set_ch(0, 16'h3000, 16'h2000);
      step_n(5, "t6.idle");
      chk("t6.hold_idle", 32'(state), 32'd0);
      start = 1'b1;
      step("t6.restart");
      start = 1'b0;
      chk("t6.soft", 32'(state), 32'd1);

      // Randomized run
      apply_reset("rnd");
      for (int n = 0; n < 1500; n++) begin
         for (int k = 0; k < NCH; k++) begin
            if ($urandom_range(0, 11) == 0) set_ch(k, pick_v(), bus.i_in[k*W +: W]);
            if ($urandom_range(0, 11) == 0) set_ch(k, bus.v_in[k*W +: W], pick_i());
         end
         bus.sample_valid = ($urandom_range(0, 7) != 0);
         start       = ($urandom_range(0, 9) == 0);
         stop        = ($urandom_range(0, 79) == 0);
         clear_fault = ($urandom_range(0, 7) == 0);
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/vi_supervisor_mc.md
Name: vi_supervisor_mc

Overview:
Multi-channel V–I safety supervisor that gates the PID controllers of NCH power channels. It generalises the INIT/RUN/FAULT supervisor with the following additions:
- runtime thresholds, including undervoltage;
- per-condition sample debouncing;
- a soft-start phase;
- bounded automatic retry with back-off, ending in a hard lockout.

It sits between the ADC sample stream and the per-channel PID enables.

Parameters:
W, 16, sample/threshold width, signed Q1.15
NCH, 2, number of monitored channels
DEBOUNCE, 4, consecutive valid out-of-range samples needed to trip (>=1)
SOFTSTART_CYC, 256, clock cycles spent in SOFT before RUN (>=1)
RETRY_MAX, 3, automatic restarts allowed before LOCKOUT (0 = lock out on first fault)
RETRY_WAIT, 1024, back-off cycles in WAIT before a retry (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request power-up from IDLE
stop  in  1  request orderly shutdown
clear_fault  in  1  release LOCKOUT
sample_valid  in  1  v_in/i_in carry a new sample this cycle
v_in  in  NCH*W  packed signed voltages; channel k = bits [k*W +: W]
i_in  in  NCH*W  packed signed currents; same packing
v_max  in  W  signed overvoltage threshold (common to all channels)
v_min  in  W  signed undervoltage threshold
i_max  in  W  signed overcurrent threshold
pid_en  out  1  PID enable
soft_start  out  1  high while in SOFT
fault  out  1  high in FAULT, WAIT, LOCKOUT
state  out  3  IDLE=0, SOFT=1, RUN=2, FAULT=3, WAIT=4, LOCKOUT=5
fault_ch  out  NCH  sticky per-channel trip flags
fault_cause  out  3  sticky {oc, uv, ov}
retry_cnt  out  $clog2(RETRY_MAX+1)  retries consumed

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; retry_cnt=0; all debounce counters 0.
  - Every output is 0.
- All outputs are registered and are updated on the same edge as state, so they reflect the new state with no lag.
- Raw per-channel conditions use strict signed comparisons:
  - ov_k = v_k > v_max
  - uv_k = v_k < v_min
  - oc_k = i_k > i_max
- Debounce: one counter per channel per condition (3*NCH counters), each $clog2(DEBOUNCE+1) bits.
  - When sample_valid=1: the counter increments (saturating at DEBOUNCE) if its condition is true, and clears if it is false.
  - When sample_valid=0: the counter holds.
  - A condition trips when its counter equals DEBOUNCE.
  - In IDLE and LOCKOUT, all counters are held at 0.
- Trip qualification:
  - ov/oc trips are active in SOFT and RUN.
  - uv trips are active only in RUN; the uv counters are held at 0 in SOFT.
  - trip_any = OR of all active trips.
- Transitions:
  - IDLE: start -> SOFT, load the soft-start timer, clear retry_cnt.
  - SOFT: pid_en=1, soft_start=1. trip_any -> FAULT; else stop -> IDLE; else when the timer reaches SOFTSTART_CYC cycles -> RUN.
  - RUN: pid_en=1. trip_any -> FAULT; else stop -> IDLE.
  - FAULT (exactly one cycle): fault=1, pid_en=0. If retry_cnt < RETRY_MAX -> WAIT and load the back-off timer; else -> LOCKOUT.
  - WAIT: fault=1. stop -> IDLE. At timer expiry:
    - if no channel has a raw ov/oc -> SOFT, retry_cnt+1, clear debounce counters;
    - else reload the timer and stay in WAIT.
  - LOCKOUT: fault=1. clear_fault with no raw ov/oc on any channel -> IDLE. That transition clears fault_ch, fault_cause and retry_cnt. stop is ignored.
  - Undefined state encodings -> IDLE with all outputs 0.
- Priorities:
  - trip beats stop beats the soft-start timer.
  - start is ignored outside IDLE; start and stop together in IDLE -> stay in IDLE.
- Sticky flags:
  - On entry to FAULT, OR the tripping channels into fault_ch and the tripping causes into fault_cause.
  - Flags accumulate across retries.
  - Only the LOCKOUT->IDLE transition clears them; reset also clears them.
- Reset asserted mid-operation: the block returns to reset values immediately, without waiting for a clock edge.

Test Plan:
Bench configuration for all scenarios: W=16, NCH=2, DEBOUNCE=4, SOFTSTART_CYC=8, RETRY_MAX=2, RETRY_WAIT=16, v_max=0x6000, v_min=0x1000, i_max=0x5000, sample_valid=1 every cycle.
1. Nominal power-up:
   - Stimulus: v=0x3000 and i=0x2000 on both channels; pulse start.
   - Response: state=SOFT with soft_start=1 for 8 cycles, then RUN with pid_en=1 and fault=0. Pulse stop -> IDLE and pid_en=0 on the next edge.
2. Debounce:
   - Stimulus: in RUN, ch1 i=0x5001 for 3 samples, 1 sample at 0x4000, then 4 samples at 0x5001.
   - Response: no trip after the first 3. FAULT on the 4th consecutive sample, with fault_ch=2'b10 and fault_cause=3'b100.
3. Undervoltage masking:
   - Stimulus: ch0 v=0x0800 throughout SOFT.
   - Response: no trip in SOFT. After RUN entry, FAULT follows 4 samples later with fault_cause=3'b010.
4. Retry and lockout:
   - Stimulus: hold ch0 v=0x7000 from RUN onward.
   - Response: FAULT -> WAIT; WAIT keeps reloading while the overvoltage is present. When v drops to 0x3000 and is later raised again, retry_cnt goes 1, then 2; the third fault -> LOCKOUT.
   - Then assert clear_fault with v=0x7000: state stays LOCKOUT. Set v=0x3000 and assert clear_fault: state=IDLE with all sticky flags 0.
5. Simultaneous events:
   - Stimulus: in RUN, stop asserted on the same cycle the 4th oc sample arrives.
   - Response: state goes to FAULT, not IDLE.
6. Async reset:
   - Stimulus: assert rst_n=0 mid-WAIT, between clock edges.
   - Response: outputs go to 0 and state to IDLE immediately. After release, the block waits in IDLE for start.
